// File: rtl/mmio_debug_master.sv
// mmio_debug_master: byte-stream host commands to single 32-bit MMIO bus accesses; DBG_MASTER_AUTOINC_EN adds the 'N' next-read opcode
module mmio_debug_master #(
  parameter int         GNT_TIMEOUT = 16,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        busReq,
  input  logic        busGnt,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic [3:0]  byteMask,
  input  logic [31:0] memReadData,
  output logic        busy
);
  localparam int TW = GNT_TIMEOUT > 1 ? $clog2(GNT_TIMEOUT) : 1;
  typedef enum logic [3:0] {S_CMD, S_ADDR, S_DATA, S_MASK, S_REQ, S_WR, S_RD0, S_RD1, S_RESP} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic op_wr;
  logic [31:0] resp;
  logic [TW-1:0] tcnt;
  logic tx_fire, is_w, is_r, is_n, expired;
  logic [31:0] nxt_addr;
  assign tx_fire = txValid && txReady;
  assign is_w = rxData == 8'h57;
  assign is_r = rxData == 8'h52;
  assign expired = GNT_TIMEOUT != 0 && tcnt == TW'(GNT_TIMEOUT - 1);
`ifdef DBG_MASTER_AUTOINC_EN
  logic [31:0] nxt;
  assign is_n = rxData == 8'h4E;
  assign nxt_addr = nxt;
  // Next sequential read lands one word past the last completed access
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nxt <= '0;
    else if (state == S_WR || state == S_RD1) nxt <= memAddress + 32'd4;
`else
  assign is_n = 1'b0;
  assign nxt_addr = memAddress;
`endif
  // State register; reset discards any command in flight and drops the bus at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_CMD;
    else state <= state_n;
  // Next state and state-decoded handshake/bus controls
  always_comb begin
    state_n = state;
    rxReady = 1'b0;
    busReq = 1'b0;
    memWrite = 1'b0;
    busy = state != S_CMD;
    case (state)
      S_CMD: begin
        rxReady = 1'b1;
        if (rxValid) state_n = (is_w || is_r) ? S_ADDR : is_n ? S_REQ : S_RESP;
      end
      S_ADDR: begin
        rxReady = 1'b1;
        if (rxValid && cnt == 2'd3) state_n = op_wr ? S_DATA : S_REQ;
      end
      S_DATA: begin
        rxReady = 1'b1;
        if (rxValid && cnt == 2'd3) state_n = S_MASK;
      end
      S_MASK: begin
        rxReady = 1'b1;
        if (rxValid) state_n = S_REQ;
      end
      S_REQ: begin
        busReq = 1'b1;
        state_n = busGnt ? (op_wr ? S_WR : S_RD0) : expired ? S_RESP : S_REQ;
      end
      S_WR: begin
        busReq = 1'b1;
        memWrite = 1'b1;
        state_n = S_RESP;
      end
      S_RD0: begin
        busReq = 1'b1;
        state_n = S_RD1;
      end
      S_RD1: begin
        busReq = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: if (tx_fire && cnt == 2'd0) state_n = S_CMD;
      default: state_n = S_CMD;
    endcase
  end
  // Field capture, grant-wait counter and response byte streaming
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      op_wr <= 1'b0;
      memAddress <= '0;
      memWriteData <= '0;
      byteMask <= '0;
      resp <= '0;
      tcnt <= '0;
      txValid <= 1'b0;
      txData <= '0;
    end else begin
      tcnt <= state == S_REQ ? tcnt + 1'b1 : '0;
      case (state)
        S_CMD: if (rxValid) begin
          cnt <= '0;
          op_wr <= is_w;
          resp <= {NAK_BYTE, 24'h0};
          if (is_n) begin
            memAddress <= nxt_addr;
            byteMask <= 4'hF;
          end
        end
        S_ADDR: if (rxValid) begin
          memAddress <= {memAddress[23:0], rxData};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3 && !op_wr) byteMask <= 4'hF;
        end
        S_DATA: if (rxValid) begin
          memWriteData <= {memWriteData[23:0], rxData};
          cnt <= cnt + 2'd1;
        end
        S_MASK: if (rxValid) byteMask <= rxData[3:0];
        S_WR: resp <= {ACK_BYTE, 24'h0};
        S_RD1: begin
          resp <= memReadData;
          cnt <= 2'd3;
        end
        S_RESP: if (tx_fire) begin
          txValid <= 1'b0;
          cnt <= cnt - 2'd1;
        end else if (!txValid) begin
          txValid <= 1'b1;
          txData <= resp[31:24];
          resp <= {resp[23:0], 8'h0};
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mmio_debug_master.sv
// tb_mmio_debug_master: randomized host commands checked against a command-level model of the debug master
`timescale 1ns/1ps
module tb_mmio_debug_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rxData = 8'h0;
  logic rxValid = 1'b0;
  logic rxReady;
  logic [7:0] txData;
  logic txValid;
  logic txReady = 1'b0;
  logic busReq;
  logic busGnt = 1'b0;
  logic [31:0] memAddress, memWriteData;
  logic memWrite;
  logic [3:0] byteMask;
  logic [31:0] memReadData = 32'h0;
  logic busy;
  int tests = 0;
  int fails = 0;
`ifdef DBG_MASTER_AUTOINC_EN
  localparam bit HAS_N = 1'b1;
`else
  localparam bit HAS_N = 1'b0;
`endif
  mmio_debug_master dut (
    .clk(clk), .rst_n(rst_n), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .txData(txData), .txValid(txValid), .txReady(txReady), .busReq(busReq), .busGnt(busGnt),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
    .byteMask(byteMask), .memReadData(memReadData), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pool [8];
  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 32'h0;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction
  logic [7:0] cmd_q[$];
  logic [7:0] got_q[$];
  int cyc = 0, req_cyc, gnt_cyc, wr_cnt, stall = 0, dly = 0, last_rx_cyc = 0, first_tx_cyc = -1;
  logic prev_g = 1'b0, prev_tv = 1'b0, prev_tr = 1'b0, w_gnt;
  logic [7:0] prev_td = 8'h0;
  logic [31:0] prev_a = 32'h0, g_first, g_last, w_addr, w_data, nxt_m = 32'h0;
  logic [3:0] g_mask, w_mask;
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (busReq) req_cyc++;
    if (busReq && busGnt) begin
      if (gnt_cyc == 0) g_first = memAddress;
      g_last = memAddress;
      g_mask = byteMask;
      gnt_cyc++;
    end
    if (memWrite) begin
      wr_cnt++;
      w_addr = memAddress;
      w_data = memWriteData;
      w_mask = byteMask;
      w_gnt = busGnt;
      if (busGnt) bus_mem[memAddress] = merge(bus_rd(memAddress), memWriteData, byteMask);
    end
    memReadData = prev_g ? bus_rd(prev_a) : $urandom;
    prev_g = busReq && busGnt && !memWrite;
    prev_a = memAddress;
    if (!busReq) busGnt = 1'b0;
    else if (!busGnt) begin
      if (dly == 0) busGnt = 1'b1;
      else dly--;
    end
    if (prev_tv && !prev_tr) begin
      check("tx_hold_valid", 32'(txValid), 32'h1);
      check("tx_hold_data", 32'(txData), 32'(prev_td));
    end
    if (txValid && first_tx_cyc < 0) first_tx_cyc = cyc;
    txReady = (txValid && stall > 0) ? 1'b0 : ($urandom_range(3) != 0);
    if (txValid && stall > 0) stall--;
    if (txValid && txReady) got_q.push_back(txData);
    prev_tv = txValid;
    prev_tr = txReady;
    prev_td = txData;
    rxValid = cmd_q.size() != 0 && $urandom_range(3) != 0;
    rxData = cmd_q.size() != 0 ? cmd_q[0] : 8'($urandom);
    if (rxValid && rxReady) begin
      void'(cmd_q.pop_front());
      last_rx_cyc = cyc;
    end
  endtask
  task automatic push32(input logic [31:0] v);
    for (int i = 3; i >= 0; i--) cmd_q.push_back(v[i*8 +: 8]);
  endtask
  // kind: 0 write, 1 read, 2 next-read, 3 other opcode (bad)
  task automatic run_cmd(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input int gdly, input logic [7:0] bad);
    logic [7:0] exp_q[$];
    logic [31:0] acc, rv;
    int exp_req, exp_gnt, exp_wr;
    bit bus_op, tmo, done;
    cmd_q.delete();
    got_q.delete();
    req_cyc = 0;
    gnt_cyc = 0;
    wr_cnt = 0;
    dly = gdly;
    first_tx_cyc = -1;
    case (kind)
      0: begin cmd_q.push_back(8'h57); push32(a); push32(d); cmd_q.push_back({4'($urandom), m}); end
      1: begin cmd_q.push_back(8'h52); push32(a); end
      2: cmd_q.push_back(8'h4E);
      default: cmd_q.push_back(bad);
    endcase
    acc = kind == 2 ? nxt_m : a;
    bus_op = kind == 0 || kind == 1 || (kind == 2 && HAS_N);
    tmo = bus_op && gdly >= 16;
    exp_gnt = 0;
    exp_wr = 0;
    exp_req = 0;
    if (!bus_op || tmo) begin
      exp_q.push_back(8'h15);
      exp_req = tmo ? 16 : 0;
    end else if (kind == 0) begin
      ref_mem[acc] = merge(ref_rd(acc), d, m);
      exp_q.push_back(8'h06);
      exp_req = gdly + 2;
      exp_gnt = 1;
      exp_wr = 1;
      nxt_m = acc + 32'd4;
    end else begin
      rv = ref_rd(acc);
      for (int i = 3; i >= 0; i--) exp_q.push_back(rv[i*8 +: 8]);
      exp_req = gdly + 3;
      exp_gnt = 2;
      nxt_m = acc + 32'd4;
    end
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      done = cmd_q.size() == 0 && got_q.size() >= exp_q.size() && !busy;
    end
    for (int i = 0; i < 3; i++) tick();
    check("cmd_done", 32'(done), 32'h1);
    check("resp_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("resp_byte%0d", i), i < got_q.size() ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    check("req_cycles", req_cyc, exp_req);
    check("gnt_cycles", gnt_cyc, exp_gnt);
    check("wr_pulses", wr_cnt, exp_wr);
    if (!bus_op) check("nak_latency_le2", 32'((first_tx_cyc - last_rx_cyc) <= 2), 32'h1);
    if (exp_wr == 1 && wr_cnt == 1) begin
      check("wr_addr", w_addr, acc);
      check("wr_data", w_data, d);
      check("wr_mask", 32'(w_mask), 32'(m));
      check("wr_granted", 32'(w_gnt), 32'h1);
    end
    if (exp_gnt == 2 && gnt_cyc == 2) begin
      check("rd_addr_first", g_first, acc);
      check("rd_addr_last", g_last, acc);
      check("rd_mask", 32'(g_mask), 32'hF);
    end
  endtask
  initial begin
    int k, g;
    logic [7:0] b;
    pool = '{32'h0, 32'h4, 32'h10, 32'h14, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'h1234_5679, 32'h8000_0000};
    #7;
    check("rst_rxReady", 32'(rxReady), 32'h1);
    check("rst_txValid", 32'(txValid), 32'h0);
    check("rst_txData", 32'(txData), 32'h0);
    check("rst_busReq", 32'(busReq), 32'h0);
    check("rst_memWrite", 32'(memWrite), 32'h0);
    check("rst_memAddress", memAddress, 32'h0);
    check("rst_memWriteData", memWriteData, 32'h0);
    check("rst_byteMask", 32'(byteMask), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_cmd(0, 32'hFFFF_FFF0, 32'h0300_0000, 4'h8, 0, 8'h0);
    run_cmd(1, 32'hFFFF_FFF0, 32'h0, 4'h0, 2, 8'h0);
    run_cmd(0, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 100, 8'h0);
    run_cmd(0, 32'h0000_0044, 32'h1122_3344, 4'hF, 15, 8'h0);
    run_cmd(0, 32'h0000_0048, 32'h5566_7788, 4'hF, 16, 8'h0);
    run_cmd(1, 32'h0000_0044, 32'h0, 4'h0, 1, 8'h0);
    run_cmd(3, 32'h0, 32'h0, 4'h0, 0, 8'h41);
    run_cmd(1, 32'hFFFF_FFF0, 32'h0, 4'h0, 0, 8'h0);
    stall = 50;
    run_cmd(1, 32'h0000_0044, 32'h0, 4'h0, 3, 8'h0);
    cmd_q.delete();
    wr_cnt = 0;
    req_cyc = 0;
    cmd_q.push_back(8'h57);
    push32(32'h0000_0080);
    cmd_q.push_back(8'hAB);
    cmd_q.push_back(8'hCD);
    for (int i = 0; i < 100 && cmd_q.size() != 0; i++) tick();
    check("partial_sent", cmd_q.size(), 0);
    tick();
    check("partial_busy", 32'(busy), 32'h1);
    check("partial_rxReady", 32'(rxReady), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_rxReady", 32'(rxReady), 32'h1);
    check("midrst_busReq", 32'(busReq), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_memWrite", 32'(memWrite), 32'h0);
    nxt_m = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midrst_no_write", wr_cnt, 0);
    check("midrst_no_req", req_cyc, 0);
    run_cmd(0, 32'h0000_0080, 32'hDEAD_BEEF, 4'h5, 1, 8'h0);
    run_cmd(1, 32'h0000_0080, 32'h0, 4'h0, 0, 8'h0);
    run_cmd(0, 32'h0000_0014, 32'hA1B2_C3D4, 4'hF, 0, 8'h0);
    run_cmd(1, 32'h0000_0010, 32'h0, 4'h0, 0, 8'h0);
    run_cmd(2, 32'h0, 32'h0, 4'h0, 0, 8'h0);
    run_cmd(1, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 8'h0);
    run_cmd(2, 32'h0, 32'h0, 4'h0, 2, 8'h0);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(9);
      k = k < 4 ? 0 : k < 7 ? 1 : k < 9 ? 2 : 3;
      g = $urandom_range(7) == 0 ? 14 + $urandom_range(3) : $urandom_range(5);
      do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h4E);
      run_cmd(k, pool[$urandom_range(7)], $urandom, 4'($urandom), g, b);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
